// File: rtl/time_disp_pkg.sv
// Shared constants and types for the multiplexed 7-segment time display.
// Segment codes are active-low and ordered {g,f,e,d,c,b,a}.
package time_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

  typedef logic [1:0] slot_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLASH = 1'b1
  } flash_state_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD values show a dash.
module seg7_decode
  import time_disp_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/time_display_driver.sv
// Drives a 4-digit multiplexed display as M.SS from snapshotted BCD digits,
// and flashes the display a fixed number of times when time_out rises.
module time_display_driver
  import time_disp_pkg::*;
#(
  parameter int SCAN_DIV      = 100000,
  parameter int GUARD         = 16,
  parameter int BLINK_DIV     = 25000000,
  parameter int FLASH_TOGGLES = 6
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [3:0] C,
  input  logic       time_out,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int FW = $clog2(FLASH_TOGGLES + 1);

  localparam logic [PW-1:0] PCNT_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] GUARD_V   = PW'(GUARD);
  localparam logic [BW-1:0] BCNT_LAST = BW'(BLINK_DIV - 1);
  localparam logic [FW-1:0] FCNT_LOAD = FW'(FLASH_TOGGLES);

  logic [PW-1:0] pcnt_q, pcnt_d;
  slot_t         slot_q, slot_d;
  logic [3:0]    snap_a_q, snap_b_q, snap_c_q;
  logic          to_s1_q, to_s2_q, to_s3_q;
  flash_state_e  state_q, state_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_on_q, phase_on_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          frame_end;
  logic          to_rise;
  logic          blank;
  logic [3:0]    digit;
  logic [6:0]    digit_seg;

  assign frame_end = (pcnt_q == PCNT_LAST) && (slot_q == 2'd3);
  assign to_rise   = to_s2_q & ~to_s3_q;
  assign blank     = (pcnt_q < GUARD_V) || !enable || !phase_on_q;

  always_comb begin
    pcnt_d = pcnt_q + 1'b1;
    slot_d = slot_q;
    if (pcnt_q == PCNT_LAST) begin
      pcnt_d = '0;
      slot_d = slot_q + 2'd1;
    end
  end

  // A rise always (re)starts the full sequence, whether idle or mid-flash.
  always_comb begin
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    bcnt_d     = bcnt_q;
    phase_on_d = phase_on_q;
    if (to_rise) begin
      state_d    = ST_FLASH;
      fcnt_d     = FCNT_LOAD;
      bcnt_d     = '0;
      phase_on_d = 1'b0;
    end else if (state_q == ST_FLASH) begin
      if (bcnt_q == BCNT_LAST) begin
        bcnt_d     = '0;
        fcnt_d     = fcnt_q - 1'b1;
        phase_on_d = ~phase_on_q;
        if (fcnt_q == FW'(1)) begin
          state_d    = ST_IDLE;
          phase_on_d = 1'b1;
        end
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    digit = snap_c_q;
    case (slot_q)
      2'd0:    digit = snap_c_q;
      2'd1:    digit = snap_b_q;
      2'd2:    digit = snap_a_q;
      default: digit = snap_c_q;
    endcase
  end

  seg7_decode u_decode (
    .digit_i (digit),
    .seg_o   (digit_seg)
  );

  // dp tracks the slot only; with the anodes off it is not visible anyway.
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    dp_d  = (slot_q != 2'd2);
    if (!blank && (slot_q != 2'd3)) begin
      an_d  = ~(4'b0001 << slot_q);
      seg_d = digit_seg;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      pcnt_q     <= '0;
      slot_q     <= '0;
      snap_a_q   <= '0;
      snap_b_q   <= '0;
      snap_c_q   <= '0;
      to_s1_q    <= 1'b0;
      to_s2_q    <= 1'b0;
      to_s3_q    <= 1'b0;
      state_q    <= ST_IDLE;
      fcnt_q     <= '0;
      bcnt_q     <= '0;
      phase_on_q <= 1'b1;
      an_q       <= AN_OFF;
      seg_q      <= SEG_BLANK;
      dp_q       <= 1'b1;
    end else begin
      pcnt_q     <= pcnt_d;
      slot_q     <= slot_d;
      to_s1_q    <= time_out;
      to_s2_q    <= to_s1_q;
      to_s3_q    <= to_s2_q;
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      bcnt_q     <= bcnt_d;
      phase_on_q <= phase_on_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      if (frame_end) begin
        snap_a_q <= A;
        snap_b_q <= B;
        snap_c_q <= C;
      end
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_time_display_driver.sv
// Bench for time_display_driver: time-indexed reference model with an expected
// queue checked every cycle, literal spot checks, then randomized traffic.
module tb_time_display_driver;

  localparam int SCAN_DIV      = 4;
  localparam int GUARD         = 1;
  localparam int BLINK_DIV     = 8;
  localparam int FLASH_TOGGLES = 4;
  localparam int FLASH_LEN     = FLASH_TOGGLES * BLINK_DIV;

  logic       clk_in = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       time_out = 1'b0;
  logic [3:0] a_in = 4'd2;
  logic [3:0] b_in = 4'd3;
  logic [3:0] c_in = 4'd7;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks = 0;
  int errors = 0;

  // model state: t = cycles since reset release, flash measured from its load edge
  int         m_t = 0;
  int         m_fel = 0;
  int         n_edge = 0;
  bit         m_flash = 1'b0;
  bit         m_valid = 1'b0;
  logic [3:0] snap_a = '0, snap_b = '0, snap_c = '0;
  bit         to_h1 = 1'b0, to_h2 = 1'b0, to_h3 = 1'b0;
  logic [11:0] exp_q[$];

  time_display_driver #(
    .SCAN_DIV      (SCAN_DIV),
    .GUARD         (GUARD),
    .BLINK_DIV     (BLINK_DIV),
    .FLASH_TOGGLES (FLASH_TOGGLES)
  ) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .enable   (enable),
    .A        (a_in),
    .B        (b_in),
    .C        (c_in),
    .time_out (time_out),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    if (d < 4'd10) return tab[int'(d)];
    return 7'h3F;
  endfunction

  always @(posedge clk_in) begin
    int p, s;
    bit dark, load;
    logic [3:0] d, an_e;
    logic [11:0] e;
    if (reset) begin
      e = {4'hF, 7'h7F, 1'b1};
      m_t = 0; m_fel = 0; m_flash = 1'b0; n_edge = 0; m_valid = 1'b1;
      snap_a = '0; snap_b = '0; snap_c = '0;
      to_h1 = 1'b0; to_h2 = 1'b0; to_h3 = 1'b0;
    end else begin
      p = m_t % SCAN_DIV;
      s = (m_t / SCAN_DIV) % 4;
      dark = (p < GUARD) || !enable || (m_flash && ((m_fel / BLINK_DIV) % 2 == 0));
      d = (s == 0) ? snap_c : (s == 1) ? snap_b : snap_a;
      an_e = (s == 0) ? 4'hE : (s == 1) ? 4'hD : 4'hB;
      if (dark || s == 3) e = {4'hF, 7'h7F, 1'(s != 2)};
      else                e = {an_e, seg_of(d), 1'(s != 2)};
      if (p == SCAN_DIV - 1 && s == 3) begin
        snap_a = a_in; snap_b = b_in; snap_c = c_in;
      end
      load = to_h2 && !to_h3;
      if (load) begin
        m_flash = 1'b1; m_fel = 0;
      end else if (m_flash) begin
        m_fel++;
        if (m_fel == FLASH_LEN) m_flash = 1'b0;
      end
      to_h3 = to_h2; to_h2 = to_h1; to_h1 = time_out;
      m_t++; n_edge++;
    end
    if (m_valid) exp_q.push_back(e);
  end

  always @(posedge clk_in) begin
    logic [11:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({an, seg, dp} !== e) begin
        errors++;
        $display("FAIL model_cycle @%0t: an/seg/dp got %h/%h/%b expected %h/%h/%b",
                 $time, an, seg, dp, e[11:8], e[7:1], e[0]);
      end
    end
  end

  task automatic check_lit(input string name, input logic [3:0] ea,
                           input logic [6:0] es, input logic ed);
    checks++;
    if (an !== ea || seg !== es || dp !== ed) begin
      errors++;
      $display("FAIL %s @%0t: an/seg/dp got %h/%h/%b expected %h/%h/%b",
               name, $time, an, seg, dp, ea, es, ed);
    end
  endtask

  task automatic wait_edge(input int n);
    int guard = 0;
    do begin
      @(posedge clk_in); #2;
      guard++;
    end while (n_edge < n && guard < 1000);
    if (n_edge != n) begin
      checks++; errors++;
      $display("FAIL wait_edge: reached edge %0d expected %0d", n_edge, n);
    end
  endtask

  initial begin
    repeat (10) begin
      @(posedge clk_in); #2;
      check_lit("reset_hold", 4'hF, 7'h7F, 1'b1);
    end
    reset = 1'b0;
    wait_edge(2);   check_lit("first_frame_zero", 4'hE, 7'h40, 1'b1);
    wait_edge(17);  check_lit("guard_slot0", 4'hF, 7'h7F, 1'b1);
    wait_edge(19);  check_lit("slot0_c7", 4'hE, 7'h78, 1'b1);
    wait_edge(22);  check_lit("slot1_b3", 4'hD, 7'h30, 1'b1);
    wait_edge(26);  check_lit("slot2_a2", 4'hB, 7'h24, 1'b0);
    wait_edge(30);  check_lit("slot3_idle", 4'hF, 7'h7F, 1'b1);
    wait_edge(35);  check_lit("frame3_slot0", 4'hE, 7'h78, 1'b1);
    wait_edge(37);  c_in = 4'd5;
    wait_edge(42);  check_lit("frame3_slot2", 4'hB, 7'h24, 1'b0);
    wait_edge(51);  check_lit("c5_next_frame", 4'hE, 7'h12, 1'b1);
    wait_edge(52);  b_in = 4'd12;
    wait_edge(70);  check_lit("dash_b12", 4'hD, 7'h3F, 1'b1);
    wait_edge(72);  enable = 1'b0;
    wait_edge(74);  check_lit("enable_blank", 4'hF, 7'h7F, 1'b0);
    wait_edge(80);  enable = 1'b1;
    wait_edge(83);  check_lit("reenable_slot0", 4'hE, 7'h12, 1'b1);
    wait_edge(96);  time_out = 1'b1;
    wait_edge(99);  check_lit("pre_flash", 4'hE, 7'h12, 1'b1);
    wait_edge(100); check_lit("flash_off_start", 4'hF, 7'h7F, 1'b1);
    wait_edge(107); check_lit("flash_off_end", 4'hF, 7'h7F, 1'b0);
    wait_edge(108); check_lit("flash_on", 4'hB, 7'h24, 1'b0);
    wait_edge(110); time_out = 1'b0;
    wait_edge(117); time_out = 1'b1;
    wait_edge(138); check_lit("restart_off", 4'hF, 7'h7F, 1'b0);
    wait_edge(146); check_lit("restart_on", 4'hE, 7'h12, 1'b1);
    wait_edge(154); check_lit("flash_done", 4'hB, 7'h24, 1'b0);
    wait_edge(158); time_out = 1'b0;
    wait_edge(160); time_out = 1'b1;
    wait_edge(165); reset = 1'b1; time_out = 1'b0;
    @(posedge clk_in); #2;
    check_lit("reset_mid_flash", 4'hF, 7'h7F, 1'b1);
    @(posedge clk_in); #2;
    reset = 1'b0;
    wait_edge(2);   check_lit("no_flash_after_reset", 4'hE, 7'h40, 1'b1);
    wait_edge(6);   check_lit("scan_after_reset", 4'hD, 7'h40, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk_in); #2;
      reset  = ($urandom_range(0, 299) == 0);
      enable = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 29) == 0) time_out = ~time_out;
      if ($urandom_range(0, 3) == 0) begin
        a_in = 4'($urandom_range(0, 15));
        b_in = 4'($urandom_range(0, 15));
        c_in = 4'($urandom_range(0, 15));
      end
    end
    reset = 1'b0;
    repeat (4) @(posedge clk_in);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
